// File: rtl/synth_param_ctrl_pkg.sv
// Shared constants for the synth control path: selector codes, note/octave limits, key width.
// key_of folds octave and note into the oscillator key number.
package synth_param_ctrl_pkg;

    typedef enum logic [2:0] {
        SEL_VOL = 3'd0,
        SEL_ATK = 3'd1,
        SEL_DCY = 3'd2,
        SEL_SUS = 3'd3,
        SEL_REL = 3'd4
    } sel_e;

    localparam int NOTE_MAX   = 11;
    localparam int OCT_MAX    = 7;
    localparam int KEY_W      = 7;
    localparam int NUM_PARAMS = 5;

    function automatic logic [KEY_W-1:0] key_of(input logic [2:0] oct, input logic [3:0] nt);
        return KEY_W'(oct) * KEY_W'(12) + KEY_W'(nt);
    endfunction

endpackage

// File: rtl/synth_param_ctrl_sync_edge.sv
// Two-flop synchroniser plus registered rising-edge detector; a held level yields one pulse.
// Pulse appears after the third clock edge following the input rise.
module synth_param_ctrl_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_lvl,
    output logic o_evt
);

    logic r_s1;
    logic r_s2;
    logic r_prev;
    logic r_evt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
            r_evt  <= 1'b0;
        end else begin
            r_s1   <= i_lvl;
            r_s2   <= r_s1;
            r_prev <= r_s2;
            r_evt  <= r_s2 & ~r_prev;
        end
    end

    assign o_evt = r_evt;

endmodule

// File: rtl/synth_param_ctrl.sv
// Keyboard-control front end: syncs decoder strobes into CLOCK_50, keeps octave and ADSR/volume
// registers, and issues note-on, a timed gate and the combined key number.
module synth_param_ctrl
    import synth_param_ctrl_pkg::*;
#(
    parameter int PARAM_W     = 4,
    parameter int STEP        = 1,
    parameter int OCT_DEFAULT = 4,
    parameter int PARAM_DEF   = 8,
    parameter int GATE_CYCLES = 25_000_000
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [3:0]         note,
    input  logic               note_in,
    input  logic               octave_minus_minus,
    input  logic               octave_plus_plus,
    input  logic               ADSR_minus_minus,
    input  logic               ADSR_plus_plus,
    input  logic [2:0]         ADSR_selector,
    output logic [2:0]         octave,
    output logic [KEY_W-1:0]   key_num,
    output logic [3:0]         note_q,
    output logic               note_on,
    output logic               gate,
    output logic [PARAM_W-1:0] vol,
    output logic [PARAM_W-1:0] atk,
    output logic [PARAM_W-1:0] dcy,
    output logic [PARAM_W-1:0] sus,
    output logic [PARAM_W-1:0] rel,
    output logic [2:0]         sel_q
);

    localparam int CNT_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [PARAM_W:0] P_MAX  = {1'b0, {PARAM_W{1'b1}}};
    localparam logic [PARAM_W:0] P_STEP = (PARAM_W+1)'(STEP);

    logic w_note_evt, w_oup, w_odn, w_pup, w_pdn;

    synth_param_ctrl_sync_edge u_se_note (.i_clk(CLOCK_50), .i_rst(reset), .i_lvl(note_in),            .o_evt(w_note_evt));
    synth_param_ctrl_sync_edge u_se_oup  (.i_clk(CLOCK_50), .i_rst(reset), .i_lvl(octave_plus_plus),   .o_evt(w_oup));
    synth_param_ctrl_sync_edge u_se_odn  (.i_clk(CLOCK_50), .i_rst(reset), .i_lvl(octave_minus_minus), .o_evt(w_odn));
    synth_param_ctrl_sync_edge u_se_pup  (.i_clk(CLOCK_50), .i_rst(reset), .i_lvl(ADSR_plus_plus),     .o_evt(w_pup));
    synth_param_ctrl_sync_edge u_se_pdn  (.i_clk(CLOCK_50), .i_rst(reset), .i_lvl(ADSR_minus_minus),   .o_evt(w_pdn));

    logic [3:0]         r_note_s1, r_note_s2, r_note_q;
    logic [2:0]         r_sel_s1, r_sel_s2, r_oct;
    logic [KEY_W-1:0]   r_key;
    logic               r_note_on, r_gate;
    logic [CNT_W-1:0]   r_cnt;
    logic [PARAM_W-1:0] r_param [NUM_PARAMS];

    logic               w_note_ok, w_sel_ok, w_pchg;
    logic [PARAM_W-1:0] w_cur, w_new;
    logic [PARAM_W:0]   w_sum;

    // Buses are stable long before their strobe, so plain 2-flop capture is enough.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_note_s1 <= '0;
            r_note_s2 <= '0;
            r_sel_s1  <= '0;
            r_sel_s2  <= '0;
        end else begin
            r_note_s1 <= note;
            r_note_s2 <= r_note_s1;
            r_sel_s1  <= ADSR_selector;
            r_sel_s2  <= r_sel_s1;
        end
    end

    assign w_note_ok = w_note_evt && (r_note_s2 <= 4'(NOTE_MAX));
    assign w_sel_ok  = (r_sel_s2 <= SEL_REL);
    assign w_pchg    = w_sel_ok && (w_pup ^ w_pdn);

    always_comb begin
        w_cur = '0;
        for (int i = 0; i < NUM_PARAMS; i++) begin
            if (r_sel_s2 == 3'(i)) w_cur = r_param[i];
        end
        w_sum = {1'b0, w_cur} + P_STEP;
        if (w_pup) begin
            w_new = (w_sum > P_MAX) ? P_MAX[PARAM_W-1:0] : w_sum[PARAM_W-1:0];
        end else begin
            w_new = ({1'b0, w_cur} < P_STEP) ? '0 : w_cur - P_STEP[PARAM_W-1:0];
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_oct     <= 3'(OCT_DEFAULT);
            r_key     <= KEY_W'(OCT_DEFAULT * 12);
            r_note_q  <= '0;
            r_note_on <= 1'b0;
            r_gate    <= 1'b0;
            r_cnt     <= '0;
            for (int i = 0; i < NUM_PARAMS; i++) r_param[i] <= PARAM_W'(PARAM_DEF);
        end else begin
            r_note_on <= w_note_ok;
            // Key uses the octave as it stood before any same-cycle octave event.
            if (w_note_ok) begin
                r_note_q <= r_note_s2;
                r_key    <= key_of(r_oct, r_note_s2);
                r_cnt    <= CNT_W'(GATE_CYCLES - 1);
                r_gate   <= 1'b1;
            end else if (r_cnt != '0) begin
                r_cnt    <= r_cnt - 1'b1;
            end else begin
                r_gate   <= 1'b0;
            end
            if (w_oup && !w_odn && r_oct != 3'(OCT_MAX)) begin
                r_oct <= r_oct + 3'd1;
            end else if (w_odn && !w_oup && r_oct != 3'd0) begin
                r_oct <= r_oct - 3'd1;
            end
            for (int i = 0; i < NUM_PARAMS; i++) begin
                if (w_pchg && r_sel_s2 == 3'(i)) r_param[i] <= w_new;
            end
        end
    end

    assign octave  = r_oct;
    assign key_num = r_key;
    assign note_q  = r_note_q;
    assign note_on = r_note_on;
    assign gate    = r_gate;
    assign sel_q   = r_sel_s2;
    assign vol     = r_param[SEL_VOL];
    assign atk     = r_param[SEL_ATK];
    assign dcy     = r_param[SEL_DCY];
    assign sus     = r_param[SEL_SUS];
    assign rel     = r_param[SEL_REL];

endmodule
